// File: rtl/serial_frame_pkg.sv
// Types and constants shared by the serial frame transmitter and its receiver.
package serial_frame_pkg;

  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/status bundle between a frame producer and serial_frame_tx.
interface serial_frame_tx_if #(
  parameter int LEN_W  = serial_frame_pkg::LEN_W,
  parameter int DATA_W = serial_frame_pkg::DATA_W
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic              serOut;
  logic              ready;
  logic              busy;
  logic              done;
  logic              lenErr;

  modport master (
    output start, len, data,
    input  serOut, ready, busy, done, lenErr
  );

  modport slave (
    input  start, len, data,
    output serOut, ready, busy, done, lenErr
  );

endinterface

// File: rtl/serial_frame_tx_bit_cnt.sv
// Loadable down-counter; tc flags that the current phase is on its last bit.
module frame_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  // next count: load wins over decrement
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en) begin
      count_d = count_q - W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == {W{1'b0}});

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, length MSB first, payload LSB first, stop bit.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int LEN_W  = serial_frame_pkg::LEN_W,
  parameter int DATA_W = serial_frame_pkg::DATA_W
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  len_sh_q, len_sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ser_out_q, ser_out_d;
  logic              len_err_q, len_err_d;
  logic              cnt_load_s, cnt_en_s, cnt_tc_s;
  logic [LEN_W-1:0]  cnt_value_s;

  frame_bit_cnt #(.W(LEN_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load_s),
    .en    (cnt_en_s),
    .value (cnt_value_s),
    .tc    (cnt_tc_s)
  );

  // next state; ser_out_d is the bit the line carries in the next state
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    len_sh_d    = len_sh_q;
    data_d      = data_q;
    ser_out_d   = STOP_BIT;
    len_err_d   = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    cnt_value_s = {LEN_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != {LEN_W{1'b0}}) begin
            state_d   = START;
            len_d     = bus.len;
            len_sh_d  = bus.len;
            data_d    = bus.data;
            ser_out_d = START_BIT;
          end else begin
            len_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d     = LEN;
        cnt_load_s  = 1'b1;
        cnt_value_s = LEN_W'(LEN_W - 1);
        ser_out_d   = len_sh_q[LEN_W-1];
        len_sh_d    = {len_sh_q[LEN_W-2:0], 1'b0};
      end
      LEN: begin
        if (cnt_tc_s) begin
          state_d     = DATA;
          cnt_load_s  = 1'b1;
          cnt_value_s = len_q - LEN_W'(1'b1);
          ser_out_d   = data_q[0];
          data_d      = {1'b0, data_q[DATA_W-1:1]};
        end else begin
          cnt_en_s  = 1'b1;
          ser_out_d = len_sh_q[LEN_W-1];
          len_sh_d  = {len_sh_q[LEN_W-2:0], 1'b0};
        end
      end
      DATA: begin
        if (cnt_tc_s) begin
          state_d   = STOP;
          ser_out_d = STOP_BIT;
        end else begin
          cnt_en_s  = 1'b1;
          ser_out_d = data_q[0];
          data_d    = {1'b0, data_q[DATA_W-1:1]};
        end
      end
      STOP: begin
        state_d   = IDLE;
        ser_out_d = STOP_BIT;
      end
      default: begin
        state_d   = IDLE;
        ser_out_d = STOP_BIT;
      end
    endcase
  end

  // state, captured frame and registered line/error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= {LEN_W{1'b0}};
      len_sh_q  <= {LEN_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      ser_out_q <= STOP_BIT;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      len_sh_q  <= len_sh_d;
      data_q    <= data_d;
      ser_out_q <= ser_out_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.serOut = ser_out_q;
  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == STOP);
  assign bus.lenErr = len_err_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx with a behavioural frame receiver for loopback.
module tb_serial_frame_tx;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   err_cnt;

  serial_frame_tx_if #(.LEN_W(4), .DATA_W(15)) bus ();

  serial_frame_tx #(.LEN_W(4), .DATA_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // request a frame for one edge, then scramble the inputs to show they are ignored
  task automatic start_frame(input logic [3:0] l, input logic [14:0] d);
    bus.start = 1'b1;
    bus.len   = l;
    bus.data  = d;
    next_cycle();
    bus.start = 1'b0;
    bus.len   = 4'($urandom);
    bus.data  = 15'($urandom);
  endtask

  // seq[n-1] is the first line bit; checks busy/done per bit and the idle cycle after
  task automatic check_seq(input string tag, input int n, input logic [31:0] seq);
    int busy_cycles;
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s bit%0d", tag, i), 32'(bus.serOut), 32'(seq[n-1-i]));
      chk($sformatf("%s done%0d", tag, i), 32'(bus.done), 32'(i == n - 1));
      if (bus.busy === 1'b1) busy_cycles++;
      next_cycle();
    end
    chk($sformatf("%s busy_cycles", tag), 32'(busy_cycles), 32'(n));
    chk($sformatf("%s ready_after", tag), 32'(bus.ready), 32'(1'b1));
    chk($sformatf("%s busy_after", tag), 32'(bus.busy), 32'(1'b0));
    chk($sformatf("%s idle_line", tag), 32'(bus.serOut), 32'(1'b1));
  endtask

  // behavioural receiver: entered in the start-bit cycle, leaves in the stop-bit cycle
  task automatic rx_frame(output logic [3:0] rl, output logic [14:0] rd,
                          output int nb, output logic er);
    er = 1'b0;
    rl = 4'd0;
    rd = 15'd0;
    nb = 0;
    if (bus.serOut !== 1'b0) er = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rl = {rl[2:0], bus.serOut};
    end
    for (int i = 0; i < int'(rl); i++) begin
      next_cycle();
      rd[i] = bus.serOut;
      nb++;
    end
    next_cycle();
    if (bus.serOut !== 1'b1 || bus.done !== 1'b1) er = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rl;
    logic [14:0] rd;
    logic [14:0] d;
    logic [15:0] mask;
    logic [8:0]  seq9;
    int          nb;
    logic        er;
    int          pos;

    chk_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len   = 4'd0;
    bus.data  = 15'd0;

    // reset state
    #12;
    chk("rst serOut", 32'(bus.serOut), 32'(1'b1));
    chk("rst ready", 32'(bus.ready), 32'(1'b1));
    chk("rst busy", 32'(bus.busy), 32'(1'b0));
    chk("rst done", 32'(bus.done), 32'(1'b0));
    chk("rst lenErr", 32'(bus.lenErr), 32'(1'b0));
    rst = 1'b0;

    // len=3 data=101 accepted on the first edge after reset
    start_frame(4'd3, 15'b101);
    check_seq("len3", 9, 32'(9'b0_0011_101_1));

    // len=15 all ones: 21 busy cycles
    start_frame(4'd15, 15'h7FFF);
    check_seq("len15", 21, 32'(21'b0_1111_111111111111111_1));

    // len=0 request rejected
    bus.start = 1'b1;
    bus.len   = 4'd0;
    bus.data  = 15'h7FFF;
    next_cycle();
    bus.start = 1'b0;
    chk("len0 lenErr", 32'(bus.lenErr), 32'(1'b1));
    chk("len0 serOut", 32'(bus.serOut), 32'(1'b1));
    chk("len0 busy", 32'(bus.busy), 32'(1'b0));
    next_cycle();
    chk("len0 lenErr_clr", 32'(bus.lenErr), 32'(1'b0));
    chk("len0 serOut2", 32'(bus.serOut), 32'(1'b1));
    chk("len0 busy2", 32'(bus.busy), 32'(1'b0));

    // start held high, len=2 data=10: frame 0,0010,0,1,1 then one idle 1
    seq9      = 9'b0_0010_01_1_1;
    bus.start = 1'b1;
    bus.len   = 4'd2;
    bus.data  = 15'b10;
    for (int c = 0; c < 27; c++) begin
      next_cycle();
      pos = c % 9;
      chk($sformatf("held c%0d line", c), 32'(bus.serOut), 32'(seq9[8-pos]));
      chk($sformatf("held c%0d ready", c), 32'(bus.ready), 32'(pos == 8));
    end
    bus.start = 1'b0;

    // reset during payload bit 2 of a len=5 frame (bit 2 is 0)
    start_frame(4'd5, 15'b11011);
    repeat (7) next_cycle();
    chk("abort pre line", 32'(bus.serOut), 32'(1'b0));
    chk("abort pre busy", 32'(bus.busy), 32'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("abort line", 32'(bus.serOut), 32'(1'b1));
    chk("abort busy", 32'(bus.busy), 32'(1'b0));
    chk("abort ready", 32'(bus.ready), 32'(1'b1));
    chk("abort done", 32'(bus.done), 32'(1'b0));
    rst = 1'b0;
    start_frame(4'd3, 15'b101);
    check_seq("post_abort", 9, 32'(9'b0_0011_101_1));

    // loopback through the receiver for every legal length
    for (int l = 1; l < 16; l++) begin
      d    = 15'($urandom);
      mask = (16'd1 << l) - 16'd1;
      start_frame(4'(l), d);
      rx_frame(rl, rd, nb, er);
      chk($sformatf("loop%0d len", l), 32'(rl), 32'(l));
      chk($sformatf("loop%0d data", l), 32'(rd), 32'(d & mask[14:0]));
      chk($sformatf("loop%0d window", l), 32'(nb), 32'(l));
      chk($sformatf("loop%0d error", l), 32'(er), 32'(1'b0));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule
